// File: rtl/argmax_classifier.sv
// argmax_classifier: consumes a stream of N_CLASSES signed scores in class
// order and reports the index and value of the largest one. Ties keep the
// lower index. All outputs come straight from registers.
module argmax_classifier #(
   parameter int N_CLASSES = 10,
   parameter int SCORE_W   = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      score_valid,
   input  logic signed [SCORE_W-1:0] score_in,
   output logic                      score_ready,
   output logic                      busy,
   output logic                      result_valid,
   output logic [3:0]                digit,
   output logic signed [SCORE_W-1:0] max_score
);

   localparam int CNT_W = $clog2(N_CLASSES + 1);
   localparam int IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t                    state_q;
   logic [CNT_W-1:0]          count_q;
   logic signed [SCORE_W-1:0] best_score_q;
   logic signed [SCORE_W-1:0] best_score_d;
   logic [IDX_W-1:0]          best_idx_q;
   logic [IDX_W-1:0]          best_idx_d;
   logic                      score_ready_q;
   logic                      busy_q;
   logic                      result_valid_q;
   logic [IDX_W-1:0]          digit_q;
   logic signed [SCORE_W-1:0] max_score_q;

   logic                      xfer;
   logic                      last_xfer;

   // Strict signed greater-than: an equal later score never displaces the
   // incumbent, which is what gives ties to the lower class index. Both
   // operands are signed, so the most-negative value orders correctly.
   function automatic logic beats(input logic signed [SCORE_W-1:0] cand,
                                  input logic signed [SCORE_W-1:0] incumbent);
      return cand > incumbent;
   endfunction

   // score_ready_q is high exactly while in COLLECT, so this is the handshake.
   assign xfer      = score_valid & score_ready_q;
   assign last_xfer = (count_q == CNT_W'(N_CLASSES - 1));

   // Running-best update for the current transfer; class 0 always seeds it.
   always_comb begin
      best_score_d = best_score_q;
      best_idx_d   = best_idx_q;
      if (xfer && ((count_q == '0) || beats(score_in, best_score_q))) begin
         best_score_d = score_in;
         best_idx_d   = IDX_W'(count_q);
      end
   end

   // Control FSM together with the registered outputs and running-best state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         count_q        <= '0;
         best_score_q   <= '0;
         best_idx_q     <= '0;
         score_ready_q  <= 1'b0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
         digit_q        <= '0;
         max_score_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               result_valid_q <= 1'b0;
               if (start) begin
                  state_q       <= COLLECT;
                  count_q       <= '0;
                  score_ready_q <= 1'b1;
                  busy_q        <= 1'b1;
               end
            end
            COLLECT: begin
               // start is deliberately ignored here: no restart mid-stream.
               if (xfer) begin
                  best_score_q <= best_score_d;
                  best_idx_q   <= best_idx_d;
                  count_q      <= count_q + 1'b1;
                  if (last_xfer) begin
                     // Publish the result together with the DONE entry so
                     // result_valid and the data appear on the same cycle.
                     state_q        <= DONE;
                     score_ready_q  <= 1'b0;
                     result_valid_q <= 1'b1;
                     digit_q        <= best_idx_d;
                     max_score_q    <= best_score_d;
                  end
               end
            end
            DONE: begin
               state_q        <= IDLE;
               result_valid_q <= 1'b0;
               busy_q         <= 1'b0;
            end
            default: begin
               state_q        <= IDLE;
               score_ready_q  <= 1'b0;
               busy_q         <= 1'b0;
               result_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign score_ready  = score_ready_q;
   assign busy         = busy_q;
   assign result_valid = result_valid_q;
   assign digit        = digit_q;
   assign max_score    = max_score_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: stimulus pushes the expected
// {digit, max_score} for each complete stream; a monitor pops on result_valid.
module tb_argmax_classifier;

   localparam int N = 10;
   localparam int W = 16;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                start = 1'b0;
   logic                score_valid = 1'b0;
   logic signed [W-1:0] score_in = '0;
   logic                score_ready;
   logic                busy;
   logic                result_valid;
   logic [3:0]          digit;
   logic signed [W-1:0] max_score;

   typedef struct {
      int d;
      int m;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   fails  = 0;
   int   last_d = 0;
   int   last_m = 0;

   argmax_classifier #(.N_CLASSES(N), .SCORE_W(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .score_valid  (score_valid),
      .score_in     (score_in),
      .score_ready  (score_ready),
      .busy         (busy),
      .result_valid (result_valid),
      .digit        (digit),
      .max_score    (max_score)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every result_valid pulse must match the oldest expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (result_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_result: digit=%0d max_score=%0d with nothing expected",
                        digit, max_score);
            end else begin
               e = exp_q.pop_front();
               if (int'(digit) != e.d || int'(max_score) != e.m) begin
                  fails++;
                  $display("FAIL result: digit=%0d max_score=%0d, expected digit=%0d max_score=%0d",
                           digit, max_score, e.d, e.m);
               end
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_ready", int'(score_ready), 1);
      chk("start_busy", int'(busy), 1);
      chk("hold_digit", int'(digit), last_d);
      chk("hold_max", int'(max_score), last_m);
   endtask

   // Sends n scores; gap idle cycles between them. restart_at pulses start
   // alongside that score index. If push, a full stream is expected to
   // complete and its result is checked. junk_in_done drives valid data
   // during the DONE cycle.
   task automatic send(input int s[N], input int n, input int gap,
                       input bit push, input int ed, input int em,
                       input int restart_at, input bit junk_in_done);
      exp_t e;
      if (push) begin
         e.d = ed;
         e.m = em;
         exp_q.push_back(e);
      end
      for (int i = 0; i < n; i++) begin
         score_valid = 1'b1;
         score_in    = W'(s[i]);
         if (i == restart_at) start = 1'b1;
         if (!score_ready) begin
            checks++;
            fails++;
            $display("FAIL ready_collect: score_ready=0 before score %0d, expected 1", i);
         end
         tick();
         start       = 1'b0;
         score_valid = 1'b0;
         if (i == N - 1) begin
            chk("latency_valid", int'(result_valid), 1);
            chk("done_busy", int'(busy), 1);
            chk("done_ready", int'(score_ready), 0);
            if (junk_in_done) begin
               score_valid = 1'b1;
               score_in    = 16'sh7fff;
            end
            tick();
            score_valid = 1'b0;
            chk("idle_valid", int'(result_valid), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_ready", int'(score_ready), 0);
            last_d = ed;
            last_m = em;
         end else begin
            for (int g = 0; g < gap; g++) begin
               chk("ready_stall", int'(score_ready), 1);
               tick();
            end
         end
      end
   endtask

   initial begin
      int s1[N];
      int s_neg[N];
      int s_ramp[N];
      int s_z[N];
      s1     = '{5, -3, 12, 7, 0, 12, -1, 3, 9, 2};
      s_neg  = '{-32768, -32768, -32768, -32768, -32768,
                 -32768, -32768, -32768, -32768, -32768};
      s_ramp = '{-5, -4, -3, -2, -1, 0, 1, 2, 3, 4};
      s_z    = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

      // Reset wins over a simultaneous start.
      reset = 1'b1;
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      chk("rst_ready", int'(score_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(result_valid), 0);
      chk("rst_digit", int'(digit), 0);
      chk("rst_max", int'(max_score), 0);

      // Start on the very first edge after reset release, back-to-back stream.
      reset = 1'b0;
      do_start();
      send(s1, N, 0, 1'b1, 2, 12, -1, 1'b0);

      // Valid data in IDLE is ignored.
      score_valid = 1'b1;
      score_in    = 16'sh7fff;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_junk_ready", int'(score_ready), 0);
         chk("idle_junk_busy", int'(busy), 0);
      end
      score_valid = 1'b0;

      // Most-negative everywhere, then junk during DONE.
      do_start();
      send(s_neg, N, 0, 1'b1, 0, -32768, -1, 1'b1);
      do_start();
      send(s_ramp, N, 0, 1'b1, 9, 4, -1, 1'b0);

      // Stalled stream: 3 idle cycles between scores.
      do_start();
      send(s1, N, 3, 1'b1, 2, 12, -1, 1'b0);

      // start re-pulsed alongside the 5th score must be ignored.
      do_start();
      send(s1, N, 0, 1'b1, 2, 12, 4, 1'b0);

      // Abort after six transfers; no result, reset clears outputs.
      do_start();
      send(s1, 6, 0, 1'b0, 0, 0, -1, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_ready", int'(score_ready), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_digit", int'(digit), 0);
      chk("abort_max", int'(max_score), 0);
      last_d = 0;
      last_m = 0;
      tick();
      do_start();
      send(s_z, N, 0, 1'b1, 9, 1, -1, 1'b0);

      tick();
      tick();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/argmax_classifier.md
ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 Parameter: N_CLASSES, 10, number of output-layer scores per inference (digits 0-9).
REQ-002 Parameter: SCORE_W, 16, width of each signed two's-complement score.
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 Port: start  input  1  one-cycle pulse from layer control marking start of output-layer score stream.
REQ-006 Port: score_valid  input  1  score_in holds a valid score this cycle.
REQ-007 Port: score_in  input  SCORE_W  signed score from output layer, class order 0..N_CLASSES-1.
REQ-008 Port: score_ready  output  1  block accepts a score this cycle.
REQ-009 Port: busy  output  1  high while collecting or reporting (state not IDLE).
REQ-010 Port: result_valid  output  1  one-cycle pulse, result outputs updated.
REQ-011 Port: digit  output  4  index of winning class.
REQ-012 Port: max_score  output  SCORE_W  signed score of winning class.

Function
REQ-013 FSM states: IDLE, COLLECT, DONE; all outputs driven from registered state/data, no combinational input-to-output paths.
REQ-014 IDLE: score_ready=0, busy=0; start=1 -> COLLECT next cycle, count cleared to 0.
REQ-015 COLLECT: score_ready=1, busy=1; transfer occurs on a cycle with score_valid=1 and score_ready=1.
REQ-016 Transfers accepted in order; k-th transfer (k from 0) is class index k; internal count width clog2(N_CLASSES+1).
REQ-017 First transfer (k=0) unconditionally loads best_score=score_in, best_idx=0.
REQ-018 Transfer k>0 replaces best only if score_in > best_score under signed comparison; ties keep lower index.
REQ-019 Cycles with score_valid=0 in COLLECT: no state change, no counter advance (stalls unbounded).
REQ-020 Transfer making count reach N_CLASSES -> DONE next cycle; score_ready=0 from that cycle on.
REQ-021 DONE (exactly one cycle): result_valid=1, digit=best_idx, max_score=best_score, busy=1; then IDLE.
REQ-022 Latency: result_valid asserted exactly one cycle after the final (N_CLASSES-th) transfer.
REQ-023 digit and max_score hold last result until next DONE; not cleared by start.
REQ-024 start in COLLECT or DONE ignored; no restart, no effect on count or best.
REQ-025 score_valid outside COLLECT ignored; no data captured.
REQ-026 Extreme values: most-negative score (-32768 at SCORE_W=16) handled as valid, correct signed ordering, no overflow.

Reset
REQ-027 reset=1 at a rising edge: state=IDLE, count=0, score_ready=0, busy=0, result_valid=0, digit=0, max_score=0, best registers=0.
REQ-028 reset overrides all other inputs same cycle, including start and an in-progress COLLECT (partial stream discarded, no result_valid).
REQ-029 First start after reset release accepted on the first clock edge with reset=0.

Verification
REQ-030 Reset, start, 10 back-to-back scores [5,-3,12,7,0,12,-1,3,9,2] -> result_valid one cycle after 10th transfer, digit=2, max_score=12 (tie at 5 keeps 2).
REQ-031 All ten scores = -32768 -> digit=0, max_score=-32768; scores [-5,-4,...,+4] -> digit=9, max_score=4.
REQ-032 Same stream as REQ-030 with score_valid low 3 cycles between each score -> identical result, result_valid pulse width 1, score_ready high throughout COLLECT.
REQ-033 start pulsed again after 4th transfer -> ignored; result still from full original stream (digit=2, max_score=12).
REQ-034 reset asserted after 6th transfer, then new start and stream [0,0,0,0,0,0,0,0,0,1] -> no result_valid for aborted stream; new result digit=9, max_score=1.
REQ-035 score_valid=1 with data while IDLE and during DONE -> no capture, score_ready=0, subsequent inference unaffected.
